instr_mem_loader: RTL and testbench

- Writer-side counterpart to the microcontroller's instruction fetch path.
- Lets an operator load a program into instruction memory one 16-bit word at a time: set the DIP switches, press the strobe button.
- Drives the memory write port and holds the CPU in reset for the whole load session.
- Sits beside the instruction memory; its o_CPU_HOLD gates the CPU reset.

---
 rtl/instr_mem_loader.sv | 165 ++++++++++++++++
 tb/tb_instr_mem_loader.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Operator-driven program loader: debounces a push button and writes one DIP-switch
// word per press into instruction memory, holding the CPU in reset for the whole session.
module instr_mem_loader #(
    parameter int ADDR_W          = 8,
    parameter int DATA_W          = 16,
    parameter int DEBOUNCE_CYCLES = 4,   // must be at least 2
    parameter int LAST_ADDR       = 255
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  logic              i_START,
    input  logic              i_STROBE,
    input  logic              i_END,
    input  logic [DATA_W-1:0] i_DIP_DATA,
    output logic              o_MEM_WE,
    output logic [ADDR_W-1:0] o_MEM_ADDR,
    output logic [DATA_W-1:0] o_MEM_DATA,
    output logic              o_CPU_HOLD,
    output logic              o_DONE,
    output logic              o_FULL,
    output logic [ADDR_W:0]   o_WORD_COUNT
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  DBC_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  DBC_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(LAST_ADDR);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   WORD_ONE = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_DEBOUNCE,
        ST_WRITE,
        ST_WAIT_RELEASE,
        ST_FINISH
    } state_t;

    state_t            state_q;
    logic              sync1_q;
    logic              sync2_q;
    logic [CNT_W-1:0]  dbc_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_data_q;
    logic              hold_q;
    logic              done_q;
    logic              full_q;
    logic [ADDR_W:0]   count_q;

    logic [CNT_W-1:0]  dbc_inc_d;
    logic [ADDR_W-1:0] ptr_inc_d;
    logic [ADDR_W:0]   count_inc_d;

    assign dbc_inc_d   = dbc_q + DBC_ONE;
    assign ptr_inc_d   = ptr_q + PTR_ONE;
    assign count_inc_d = count_q + WORD_ONE;

    // The same counter serves press debounce and release debounce; the two never overlap.
    always_ff @(posedge i_CLK) begin
        if (!i_RST) begin
            state_q    <= ST_IDLE;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            dbc_q      <= '0;
            ptr_q      <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            hold_q     <= 1'b0;
            done_q     <= 1'b0;
            full_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            sync1_q  <= i_STROBE;
            sync2_q  <= sync1_q;
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    hold_q <= 1'b0;
                    if (i_START) begin
                        state_q <= ST_ARMED;
                        hold_q  <= 1'b1;
                        ptr_q   <= '0;
                        count_q <= '0;
                        full_q  <= 1'b0;
                    end
                end

                ST_ARMED: begin
                    if (i_END) begin
                        state_q <= ST_FINISH;
                        done_q  <= 1'b1;
                    end else if (sync2_q) begin
                        state_q <= ST_DEBOUNCE;
                        dbc_q   <= DBC_ONE;
                    end
                end

                // END is deliberately not looked at here; a held END wins once back in ARMED.
                ST_DEBOUNCE: begin
                    if (!sync2_q) begin
                        state_q <= ST_ARMED;
                    end else if (dbc_inc_d == DBC_MAX) begin
                        state_q    <= ST_WRITE;
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= ptr_q;
                        mem_data_q <= i_DIP_DATA;
                    end else begin
                        dbc_q <= dbc_inc_d;
                    end
                end

                ST_WRITE: begin
                    count_q <= count_inc_d;
                    if (ptr_q == LAST) begin
                        full_q  <= 1'b1;
                        state_q <= ST_FINISH;
                        done_q  <= 1'b1;
                    end else begin
                        ptr_q   <= ptr_inc_d;
                        dbc_q   <= '0;
                        state_q <= ST_WAIT_RELEASE;
                    end
                end

                ST_WAIT_RELEASE: begin
                    if (i_END) begin
                        state_q <= ST_FINISH;
                        done_q  <= 1'b1;
                    end else if (sync2_q) begin
                        dbc_q <= '0;
                    end else if (dbc_inc_d == DBC_MAX) begin
                        state_q <= ST_ARMED;
                    end else begin
                        dbc_q <= dbc_inc_d;
                    end
                end

                ST_FINISH: begin
                    hold_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                    hold_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_MEM_WE     = mem_we_q;
    assign o_MEM_ADDR   = mem_addr_q;
    assign o_MEM_DATA   = mem_data_q;
    assign o_CPU_HOLD   = hold_q;
    assign o_DONE       = done_q;
    assign o_FULL       = full_q;
    assign o_WORD_COUNT = count_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: a sliding-window model of the loader session, a per-cycle
// output compare, an expected-write queue, and directed operator scenarios.
module tb_instr_mem_loader;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int DBC    = 4;
    localparam int LAST   = 3;

    localparam int PH_IDLE  = 0;
    localparam int PH_READY = 1;
    localparam int PH_WROTE = 2;
    localparam int PH_HELD  = 3;
    localparam int PH_CLOSE = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              strobe;
    logic              end_in;
    logic [DATA_W-1:0] dip;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              hold;
    logic              done;
    logic              full;
    logic [ADDR_W:0]   count;

    instr_mem_loader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEBOUNCE_CYCLES(DBC), .LAST_ADDR(LAST)
    ) dut (
        .i_CLK(clk), .i_RST(rst), .i_START(start), .i_STROBE(strobe), .i_END(end_in),
        .i_DIP_DATA(dip), .o_MEM_WE(we), .o_MEM_ADDR(addr), .o_MEM_DATA(wdata),
        .o_CPU_HOLD(hold), .o_DONE(done), .o_FULL(full), .o_WORD_COUNT(count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_done   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    int                ph = PH_IDLE;
    bit                win[$];
    logic              r1 = 1'b0, r2 = 1'b0, s;
    logic              m_we = 1'b0, m_hold = 1'b0, m_done = 1'b0, m_full = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0, m_ptr = '0;
    logic [DATA_W-1:0] m_data = '0;
    logic [ADDR_W:0]   m_count = '0;
    bit                m_valid = 1'b0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];

    function automatic bit win_all(input bit v);
        if (win.size() != DBC) return 1'b0;
        foreach (win[i]) if (win[i] != v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step();
        if (!rst) begin
            ph = PH_IDLE; win.delete(); r1 = 1'b0; r2 = 1'b0;
            m_we = 1'b0; m_hold = 1'b0; m_done = 1'b0; m_full = 1'b0;
            m_addr = '0; m_ptr = '0; m_data = '0; m_count = '0;
        end else begin
            s = r2; r2 = r1; r1 = strobe;
            m_we = 1'b0; m_done = 1'b0;
            case (ph)
                PH_IDLE: if (start) begin
                    ph = PH_READY; win.delete();
                    m_hold = 1'b1; m_ptr = '0; m_count = '0; m_full = 1'b0;
                end
                PH_READY: begin
                    // END only counts while no press is in progress
                    if (end_in && (win.size() == 0 || win[$] == 1'b0)) begin
                        ph = PH_CLOSE; m_done = 1'b1;
                    end else begin
                        win.push_back(s);
                        if (win.size() > DBC) void'(win.pop_front());
                        if (win_all(1'b1)) begin
                            ph = PH_WROTE; m_we = 1'b1; m_addr = m_ptr; m_data = dip;
                            exp_q.push_back({m_ptr, dip});
                        end
                    end
                end
                PH_WROTE: begin
                    m_count = m_count + 1'b1;
                    if (m_ptr == LAST) begin
                        m_full = 1'b1; m_done = 1'b1; ph = PH_CLOSE;
                    end else begin
                        m_ptr = m_ptr + 1'b1; win.delete(); ph = PH_HELD;
                    end
                end
                PH_HELD: begin
                    if (end_in) begin
                        ph = PH_CLOSE; m_done = 1'b1;
                    end else begin
                        win.push_back(s);
                        if (win.size() > DBC) void'(win.pop_front());
                        if (win_all(1'b0)) begin
                            ph = PH_READY; win.delete();
                        end
                    end
                end
                default: begin
                    m_hold = 1'b0; ph = PH_IDLE;
                end
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        model_step();
        m_valid = 1'b1;
    end

    // per-cycle compare against the model
    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            check("cyc_we", we, m_we);
            check("cyc_addr", addr, m_addr);
            check("cyc_data", wdata, m_data);
            check("cyc_hold", hold, m_hold);
            check("cyc_done", done, m_done);
            check("cyc_full", full, m_full);
            check("cyc_count", count, m_count);
        end
    end

    // write monitor: records observed writes and matches them to the expected queue
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [DATA_W-1:0] wr_data_q[$];
    int                wr_cyc_q[$];

    initial forever begin
        @(negedge clk);
        if (done === 1'b1) n_done++;
        if (we === 1'b1) begin
            wr_addr_q.push_back(addr);
            wr_data_q.push_back(wdata);
            wr_cyc_q.push_back(cyc);
            check("wr_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("wr_pair", {addr, wdata}, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [DATA_W-1:0] w, input int hi, input int lo);
        dip = w; strobe = 1'b1; tick(hi);
        strobe = 1'b0; tick(lo);
    endtask

    task automatic start_session();
        start = 1'b1; tick(1);
        start = 1'b0; tick(2);
    endtask

    task automatic end_session(input string tag);
        int d0;
        d0 = n_done;
        end_in = 1'b1; tick(2);
        end_in = 1'b0; tick(2);
        check({tag, "_done"}, n_done - d0, 1);
    endtask

    // ---------------- directed scenarios ----------------
    int n0, t0, d0;
    logic dn[6];
    logic hd[6];

    initial begin
        rst = 1'b0; start = 1'b1; strobe = 1'b1; end_in = 1'b0; dip = '0;

        // reset with START and STROBE asserted
        tick(2);
        check("rst_we", we, 0);
        check("rst_hold", hold, 0);
        check("rst_done", done, 0);
        check("rst_count", count, 0);
        check("rst_addr", addr, 0);
        rst = 1'b1; start = 1'b0; strobe = 1'b0;
        tick(2);

        // single word with latency check
        start_session();
        check("t2_hold", hold, 1);
        n0 = wr_addr_q.size();
        dip = 16'hA5C3; strobe = 1'b1; t0 = cyc;
        tick(10); strobe = 1'b0; tick(10);
        check("t2_nwr", wr_addr_q.size() - n0, 1);
        if (wr_addr_q.size() > n0) begin
            check("t2_addr", wr_addr_q[n0], 0);
            check("t2_data", wr_data_q[n0], 16'hA5C3);
            check("t2_latency", wr_cyc_q[n0] - t0, 6);
        end
        check("t2_count", count, 1);
        check("t2_hold_after", hold, 1);
        end_session("t2");

        // bouncing button, then one stable press
        start_session();
        n0 = wr_addr_q.size();
        dip = 16'hBEEF;
        repeat (5) begin
            strobe = 1'b1; tick(3);
            strobe = 1'b0; tick(1);
        end
        check("t3_bounce_nwr", wr_addr_q.size() - n0, 0);
        press(16'h1234, 10, 10);
        check("t3_nwr", wr_addr_q.size() - n0, 1);
        if (wr_addr_q.size() > n0) begin
            check("t3_addr", wr_addr_q[n0], 0);
            check("t3_data", wr_data_q[n0], 16'h1234);
        end
        check("t3_count", count, 1);
        end_session("t3");

        // three words, short END during debounce, stray START, END held to finish
        start_session();
        n0 = wr_addr_q.size();
        press(16'h0001, 8, 8);
        dip = 16'h0002; strobe = 1'b1; tick(3);
        end_in = 1'b1; tick(1);
        end_in = 1'b0; tick(4);
        strobe = 1'b0; tick(8);
        check("t4_not_ended", hold, 1);
        start = 1'b1; tick(1);
        start = 1'b0; tick(1);
        check("t4_start_ignored", count, 2);
        press(16'h0003, 8, 8);
        check("t4_nwr", wr_addr_q.size() - n0, 3);
        if (wr_addr_q.size() >= n0 + 3) begin
            check("t4_addr0", wr_addr_q[n0], 0);
            check("t4_addr1", wr_addr_q[n0+1], 1);
            check("t4_addr2", wr_addr_q[n0+2], 2);
            check("t4_data1", wr_data_q[n0+1], 16'h0002);
        end
        end_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            dn[i] = done;
            hd[i] = hold;
        end
        end_in = 1'b0;
        check("t4_done_first", dn[0], 1);
        check("t4_hold_with_done", hd[0], 1);
        check("t4_done_width", dn[1], 0);
        check("t4_hold_falls", hd[1], 0);
        check("t4_count", count, 3);
        tick(2);

        // fill to LAST_ADDR, then a press that must be ignored
        start_session();
        n0 = wr_addr_q.size();
        d0 = n_done;
        for (int k = 0; k < 4; k++) press(16'hF000 | 16'(k), 8, 8);
        check("t5_nwr", wr_addr_q.size() - n0, 4);
        if (wr_addr_q.size() >= n0 + 4) begin
            check("t5_addr3", wr_addr_q[n0+3], 3);
            check("t5_data3", wr_data_q[n0+3], 16'hF003);
        end
        check("t5_full", full, 1);
        check("t5_auto_done", n_done - d0, 1);
        check("t5_hold", hold, 0);
        press(16'hDEAD, 8, 8);
        check("t5_extra_nwr", wr_addr_q.size() - n0, 4);
        check("t5_count", count, 4);
        check("t5_full_held", full, 1);

        // reset in the middle of a session
        start_session();
        press(16'h0111, 8, 8);
        press(16'h0222, 8, 8);
        check("t6_count_pre", count, 2);
        rst = 1'b0; tick(1);
        check("t6_count", count, 0);
        check("t6_hold", hold, 0);
        check("t6_full", full, 0);
        check("t6_data", wdata, 0);
        rst = 1'b1; tick(2);
        start_session();
        n0 = wr_addr_q.size();
        press(16'h0BAD, 8, 8);
        check("t6_nwr", wr_addr_q.size() - n0, 1);
        if (wr_addr_q.size() > n0) begin
            check("t6_addr", wr_addr_q[n0], 0);
            check("t6_wdata", wr_data_q[n0], 16'h0BAD);
        end
        end_session("t6");

        check("exp_q_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
